// File: rtl/bank_queue_pkg.sv
// bank_queue_pkg: shared state type, width helper and default widths for the bank queue blocks
package bank_queue_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} wt_state_t;
  localparam int PCOUNT_W_DEF = 3;
  localparam int TCOUNT_W_DEF = 2;
  localparam int SVC_TIME_DEF = 3;
  localparam int WTIME_W_DEF  = 8;
  function automatic int max(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/wait_time_calc_if.sv
// wait_time_calc_if: request/response handshake bundle between queue counter and display logic
interface wait_time_calc_if import bank_queue_pkg::*; #(
  parameter int PCOUNT_W = PCOUNT_W_DEF,
  parameter int TCOUNT_W = TCOUNT_W_DEF,
  parameter int WTIME_W  = WTIME_W_DEF
);
  logic                req_valid;
  logic                req_ready;
  logic [PCOUNT_W-1:0] pcount;
  logic [TCOUNT_W-1:0] tcount;
  logic                resp_valid;
  logic                resp_ready;
  logic [WTIME_W-1:0]  wtime;
  logic                resp_err;
  logic                resp_sat;
  modport master (
    output req_valid, pcount, tcount, resp_ready,
    input  req_ready, resp_valid, wtime, resp_err, resp_sat
  );
  modport slave (
    input  req_valid, pcount, tcount, resp_ready,
    output req_ready, resp_valid, wtime, resp_err, resp_sat
  );
endinterface

// File: rtl/wait_time_calc_seq_divider.sv
// seq_divider: restoring divider producing one quotient bit per cycle, MSB first
module seq_divider #(
  parameter int NUM_W = 6,
  parameter int DEN_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quot,
  output logic [DEN_W:0]   rem
);
  localparam int CNT_W = $clog2(NUM_W + 1);
  logic [NUM_W-1:0] q_q, q_d;
  logic [DEN_W:0]   r_q, r_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [DEN_W:0]   shifted, diff;
  logic             fits;
  // quotient register doubles as the numerator shifter: numerator bits leave at the top, quotient bits enter at the bottom
  always_comb begin
    shifted = {r_q[DEN_W-1:0], q_q[NUM_W-1]};
    diff    = shifted - {1'b0, den_q};
    fits    = shifted >= {1'b0, den_q};
    q_d     = q_q;
    r_d     = r_q;
    den_d   = den_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (start && !busy_q) begin
      q_d    = num;
      r_d    = '0;
      den_d  = den;
      cnt_d  = CNT_W'(NUM_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      q_d    = {q_q[NUM_W-2:0], fits};
      r_d    = fits ? diff : shifted;
      cnt_d  = cnt_q - CNT_W'(1);
      busy_d = cnt_q != CNT_W'(1);
      done_d = cnt_q == CNT_W'(1);
    end
  end
  // divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      r_q    <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      r_q    <= r_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign quot = q_q;
  assign rem  = r_q;
endmodule

// File: rtl/wait_time_calc.sv
// wait_time_calc: sequential expected-wait computation with error and saturation reporting
module wait_time_calc import bank_queue_pkg::*; #(
  parameter int PCOUNT_W = PCOUNT_W_DEF,
  parameter int TCOUNT_W = TCOUNT_W_DEF,
  parameter int SVC_TIME = SVC_TIME_DEF,
  parameter int WTIME_W  = WTIME_W_DEF
) (
  input logic             clk,
  input logic             rst,
  wait_time_calc_if.slave bus
);
  localparam int SUM_W = max(PCOUNT_W, TCOUNT_W) + 1;
  localparam int SVC_W = $clog2(SVC_TIME + 1);
  localparam int NUM_W = SUM_W + SVC_W;
  localparam int EXT_W = max(NUM_W, WTIME_W);
  wt_state_t          state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic [WTIME_W-1:0] wtime_q, wtime_d;
  logic               err_q, err_d;
  logic               sat_q, sat_d;
  logic [SUM_W-1:0]   sum;
  logic [NUM_W-1:0]   num;
  logic [NUM_W-1:0]   div_quot;
  logic [EXT_W-1:0]   q_ext;
  logic               q_sat;
  logic               div_start, div_done;
  logic               unused_busy;
  logic [TCOUNT_W:0]  unused_rem;
  seq_divider #(.NUM_W(NUM_W), .DEN_W(TCOUNT_W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (num),
    .den   (bus.tcount),
    .busy  (unused_busy),
    .done  (div_done),
    .quot  (div_quot),
    .rem   (unused_rem)
  );
  // numerator and quotient clamp; SUM_W/NUM_W are sized so neither can overflow
  always_comb begin
    sum   = SUM_W'(bus.pcount) + SUM_W'(bus.tcount) - SUM_W'(1);
    num   = NUM_W'(SVC_TIME) * NUM_W'(sum);
    q_ext = EXT_W'(div_quot);
    q_sat = q_ext > EXT_W'({WTIME_W{1'b1}});
  end
  // FSM: accept in IDLE, divide in CALC, hold the result in DONE until consumed
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    wtime_d      = wtime_q;
    err_d        = err_q;
    sat_d        = sat_q;
    div_start    = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        req_ready_d = 1'b0;
        wtime_d     = '0;
        sat_d       = 1'b0;
        err_d       = bus.tcount == '0;
        div_start   = bus.tcount != '0 && bus.pcount != '0;
        state_d     = div_start ? CALC : DONE;
      end
      CALC: if (div_done) begin
        state_d      = DONE;
        resp_valid_d = 1'b1;
        sat_d        = q_sat;
        wtime_d      = q_sat ? '1 : WTIME_W'(q_ext);
      end
      DONE: if (!resp_valid_q) begin
        resp_valid_d = 1'b1;
      end else if (bus.resp_ready) begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      wtime_q      <= '0;
      err_q        <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      wtime_q      <= wtime_d;
      err_q        <= err_d;
      sat_q        <= sat_d;
    end
  end
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.wtime      = wtime_q;
  assign bus.resp_err   = err_q;
  assign bus.resp_sat   = sat_q;
endmodule

// File: tb/tb_wait_time_calc.sv
// tb_wait_time_calc: directed self-checking bench for wait_time_calc
module tb_wait_time_calc;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  wait_time_calc_if #(.PCOUNT_W(3), .TCOUNT_W(2), .WTIME_W(8)) bus ();
  wait_time_calc_if #(.PCOUNT_W(3), .TCOUNT_W(2), .WTIME_W(8)) bus40 ();
  wait_time_calc #(.PCOUNT_W(3), .TCOUNT_W(2), .SVC_TIME(3), .WTIME_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  wait_time_calc #(.PCOUNT_W(3), .TCOUNT_W(2), .SVC_TIME(40), .WTIME_W(8)) dut40 (
    .clk (clk),
    .rst (rst),
    .bus (bus40)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input int t);
    int w = 0;
    bus.req_valid = 1'b1;
    bus.pcount    = 3'(p);
    bus.tcount    = 2'(t);
    while (!bus.req_ready && w < 20) begin
      tick();
      w++;
    end
    check("send_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.resp_valid && n < 40);
  endtask

  task automatic ack();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("ack_req_ready", bus.req_ready, 1);
    check("ack_resp_valid", bus.resp_valid, 0);
  endtask

  task automatic xact(input string tag, input int p, input int t, input int exp_w, input int exp_err, input int exp_lat);
    int n;
    send(p, t);
    wait_resp(n);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_wtime"}, bus.wtime, exp_w);
    check({tag, "_err"}, bus.resp_err, exp_err);
    check({tag, "_sat"}, bus.resp_sat, 0);
    ack();
  endtask

  initial begin
    int n;
    int stale;
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.pcount       = '0;
    bus.tcount       = '0;
    bus.resp_ready   = 1'b0;
    bus40.req_valid  = 1'b0;
    bus40.pcount     = '0;
    bus40.tcount     = '0;
    bus40.resp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_wtime", bus.wtime, 0);
    check("rst_err", bus.resp_err, 0);
    check("rst_sat", bus.resp_sat, 0);
    check("rst40_req_ready", bus40.req_ready, 1);
    check("rst40_resp_valid", bus40.resp_valid, 0);

    xact("p5t1", 5, 1, 15, 0, 7);
    xact("p7t2", 7, 2, 12, 0, 7);
    xact("p4t3", 4, 3, 6, 0, 7);
    xact("p2t2", 2, 2, 4, 0, 7);
    xact("p0t2", 0, 2, 0, 0, 1);
    xact("p4t0", 4, 0, 0, 1, 1);

    for (int p = 0; p < 8; p++)
      for (int t = 1; t < 4; t++)
        xact($sformatf("sweep_p%0dt%0d", p, t), p, t, p == 0 ? 0 : (3 * (p + t - 1)) / t, 0, p == 0 ? 1 : 7);

    bus40.req_valid = 1'b1;
    bus40.pcount    = 3'd7;
    bus40.tcount    = 2'd1;
    check("sat_req_ready", bus40.req_ready, 1);
    tick();
    bus40.req_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus40.resp_valid && n < 40);
    check("sat_lat", n, 11);
    check("sat_wtime", bus40.wtime, 255);
    check("sat_flag", bus40.resp_sat, 1);
    check("sat_err", bus40.resp_err, 0);
    bus40.resp_ready = 1'b1;
    tick();
    bus40.resp_ready = 1'b0;
    check("sat_ack_req_ready", bus40.req_ready, 1);
    check("sat_ack_resp_valid", bus40.resp_valid, 0);

    send(5, 1);
    wait_resp(n);
    check("hold_lat", n, 7);
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = (i % 2) == 0;
      bus.pcount    = 3'(i);
      tick();
      check($sformatf("hold%0d_wtime", i), bus.wtime, 15);
      check($sformatf("hold%0d_req_ready", i), bus.req_ready, 0);
      check($sformatf("hold%0d_resp_valid", i), bus.resp_valid, 1);
    end
    bus.req_valid  = 1'b1;
    bus.pcount     = 3'd2;
    bus.tcount     = 2'd2;
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("release_req_ready", bus.req_ready, 1);
    check("release_resp_valid", bus.resp_valid, 0);
    tick();
    bus.req_valid = 1'b0;
    check("next_accepted", bus.req_ready, 0);
    wait_resp(n);
    check("next_lat", n, 7);
    check("next_wtime", bus.wtime, 4);
    ack();

    send(5, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_req_ready", bus.req_ready, 1);
    check("midrst_resp_valid", bus.resp_valid, 0);
    check("midrst_wtime", bus.wtime, 0);
    stale = 0;
    repeat (12) begin
      tick();
      if (bus.resp_valid) stale++;
    end
    check("midrst_no_stale", stale, 0);
    xact("after_rst", 2, 2, 4, 0, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wait_time_calc.md
# wait_time_calc

Parametrised, sequential successor to the bank queue's fixed wait-time lookup. It computes the expected customer wait time from the number of people queued and the number of open tellers. The result is `wtime = 0` if `pcount == 0`, else `floor(SVC_TIME * (pcount + tcount - 1) / tcount)`. It sits between the queue counter and the display/announcer logic and uses a valid/ready handshake on both sides. With default parameters and `tcount` in 1..3, results equal the legacy 24-entry table. It adds the `tcount == 0` error and saturation reporting.

## Interface
- `PCOUNT_W`, default 3: width of the people count.
- `TCOUNT_W`, default 2: width of the teller count.
- `SVC_TIME`, default 3: service time per customer in minutes; must be at least 1.
- `WTIME_W`, default 8: width of the wait-time output.
- Derived: `SUM_W = max(PCOUNT_W, TCOUNT_W) + 1`, `SVC_W = $clog2(SVC_TIME + 1)`, `NUM_W = SUM_W + SVC_W` (6 with defaults).

Ports, clock and reset first:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `pcount` in `PCOUNT_W`: people in queue.
- `tcount` in `TCOUNT_W`: open tellers.
- `resp_valid` out 1: result present.
- `resp_ready` in 1: consumer accepts the result.
- `wtime` out `WTIME_W`: wait time in minutes.
- `resp_err` out 1: `tcount` was 0.
- `resp_sat` out 1: quotient exceeded `2^WTIME_W - 1` and was clamped.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - `req_ready = 1`.
  - On `req_valid`, latch the inputs. If `tcount == 0`, go to DONE with `wtime = 0` and `resp_err = 1`. Else if `pcount == 0`, go to DONE with `wtime = 0`. Else load numerator `N = SVC_TIME * (pcount + tcount - 1)` (`NUM_W` bits, no overflow by construction) and divisor `tcount`, then go to CALC.
- CALC:
  - Restoring divider, one quotient bit per cycle, MSB first, for exactly `NUM_W` cycles, then DONE.
  - Remainder register is `TCOUNT_W + 1` bits.
- DONE:
  - `resp_valid = 1`; outputs are held stable while `resp_ready = 0`.
  - On `resp_ready`, go to IDLE.
- Result width: if the quotient is at least `2^WTIME_W`, output `wtime` all ones with `resp_sat = 1`; otherwise output the zero-extended quotient.
- `req_ready` is 0 in CALC and DONE. There is a single outstanding request; inputs are ignored while busy.
- Reset values: state IDLE; `req_ready = 1`; `resp_valid = 0`; `wtime = 0`; `resp_err = 0`; `resp_sat = 0`; datapath registers 0.
- Reset mid-CALC or mid-DONE: the pending result is discarded and no `resp_valid` pulse is produced.

## Timing
- Request accepted at rising edge k (`req_valid && req_ready`).
- Normal path: CALC occupies cycles k+1 .. k+`NUM_W`; `resp_valid` is high after edge k+`NUM_W`+1 (7 edges with defaults).
- Fast path (`pcount == 0` or `tcount == 0`): `resp_valid` is high after edge k+1.
- A response handshake at edge m makes `req_ready` high after edge m. There is no same-cycle response/request overlap; the earliest next accept is edge m+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `bank_queue_pkg` holds:
  - the state enum `wt_state_t` (IDLE, CALC, DONE);
  - the `max` function used for `SUM_W`;
  - default width localparams shared with the queue counter.
- One sub-module, `seq_divider`, parametrised by `NUM_W` and `DEN_W`. It has ports `start`, `num`, `den`, `busy`, `done`, `quot`, `rem`. `wait_time_calc` owns the FSM, fast path, saturation and handshake.

## Test plan
- `pcount = 5`, `tcount = 1`, defaults -> `wtime = 15`; `resp_valid` 7 edges after accept; `resp_err = 0`, `resp_sat = 0`.
- Sweep `pcount` 0..7 × `tcount` 1..3, defaults -> matches the legacy values. Spot checks: (7,2) -> 12, (4,3) -> 6, (2,2) -> 4.
- `pcount = 0`, `tcount = 2` -> `wtime = 0` one edge after accept. `tcount = 0`, `pcount = 4` -> `wtime = 0` and `resp_err = 1` one edge after accept.
- `SVC_TIME = 40`, `pcount = 7`, `tcount = 1` -> `wtime = 255`, `resp_sat = 1`.
- Hold `resp_ready = 0` for 5 cycles in DONE while toggling `req_valid`/`pcount` -> `wtime` stable, `req_ready = 0`, no new accept; the release then accepts the next request one edge later.
- Assert `rst` in the third CALC cycle -> next cycle IDLE, `req_ready = 1`, `resp_valid = 0`, and no stale response ever appears.
